// File: rtl/fram_bridge_pkg.sv
// fram_bridge_pkg: shared types and helpers for CPU-to-FRAM bus bridges.
//   - State encoding of the read-modify-write bridge FSM.
//   - BE_FULL: byte-enable pattern for a whole-word store.
//   - merge_bytes(): byte-lane merge of new store data into an old word.
package fram_bridge_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WLO   = 3'd2;
    localparam logic [2:0] ST_RD_WHI   = 3'd3;
    localparam logic [2:0] ST_WR_ISSUE = 3'd4;
    localparam logic [2:0] ST_WR_WLO   = 3'd5;
    localparam logic [2:0] ST_WR_WHI   = 3'd6;
    localparam logic [2:0] ST_RESP     = 3'd7;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StRdIssue = ST_RD_ISSUE,
        StRdWlo   = ST_RD_WLO,
        StRdWhi   = ST_RD_WHI,
        StWrIssue = ST_WR_ISSUE,
        StWrWlo   = ST_WR_WLO,
        StWrWhi   = ST_WR_WHI,
        StResp    = ST_RESP
    } state_e;

    localparam logic [3:0] BE_FULL = 4'b1111;

    // Byte i of the result comes from new_word when be[i] is set, else from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/fram_rmw_bridge.sv
// fram_rmw_bridge: converts byte-enabled CPU loads/stores into whole-word requests on the
// FRAM controller strobe/ready interface. Partial stores are done as read-modify-write; a
// one-word read buffer (data/tag/valid) serves repeated loads without a controller access.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   cpu_valid_i          request strobe, sampled only when idle
//   cpu_we_i             1 = store, 0 = load
//   cpu_be_i[3:0]        store byte enables (ignored for loads)
//   cpu_addr_i[15:0]     byte address, bits [1:0] ignored
//   cpu_wdata_i[31:0]    store data
//   cpu_rdata_o[31:0]    load data, held until the next completed load
//   cpu_ready_o          one-cycle completion pulse
//   cpu_busy_o           high from acceptance until cpu_ready_o
//   mem_read_en_o        one-cycle read strobe
//   mem_write_en_o       one-cycle write strobe
//   mem_addr_o[15:0]     word-aligned access address
//   mem_wdata_o[31:0]    merged write word
//   mem_rdata_i[31:0]    controller read data
//   mem_req_ready_i      controller idle / access complete
module fram_rmw_bridge
    import fram_bridge_pkg::*;
#(
    parameter bit BUF_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_valid_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_be_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    output logic        cpu_busy_o,
    output logic        mem_read_en_o,
    output logic        mem_write_en_o,
    output logic [15:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_req_ready_i
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [13:0] buf_tag_q, buf_tag_d;
    logic        buf_valid_q, buf_valid_d;

    logic        req_hit;    // incoming request address hits the buffer
    logic        cur_match;  // latched access address matches the buffer tag

    assign req_hit   = BUF_EN && buf_valid_q && (buf_tag_q == cpu_addr_i[15:2]);
    assign cur_match = buf_valid_q && (buf_tag_q == mem_addr_q[15:2]);

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        buf_data_d    = buf_data_q;
        buf_tag_d     = buf_tag_q;
        buf_valid_d   = buf_valid_q;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_valid_i) begin
                    we_d       = cpu_we_i;
                    be_d       = cpu_be_i;
                    wdata_d    = cpu_wdata_i;
                    mem_addr_d = {cpu_addr_i[15:2], 2'b00};
                    if (!cpu_we_i) begin
                        if (req_hit) begin
                            rdata_d = buf_data_q;
                            state_d = StResp;
                        end else begin
                            state_d = StRdIssue;
                        end
                    end else if (cpu_be_i == 4'b0000) begin
                        state_d = StResp;
                    end else if (cpu_be_i == BE_FULL) begin
                        mem_wdata_d = cpu_wdata_i;
                        state_d     = StWrIssue;
                    end else if (req_hit) begin
                        // Buffer holds the current word, so the old bytes need no read.
                        mem_wdata_d = merge_bytes(buf_data_q, cpu_wdata_i, cpu_be_i);
                        state_d     = StWrIssue;
                    end else begin
                        state_d = StRdIssue;
                    end
                end
            end
            StRdIssue: begin
                if (mem_req_ready_i) begin
                    mem_read_en_o = 1'b1;
                    state_d       = StRdWlo;
                end
            end
            StRdWlo: begin
                if (!mem_req_ready_i) state_d = StRdWhi;
            end
            StRdWhi: begin
                if (mem_req_ready_i) begin
                    buf_data_d  = mem_rdata_i;
                    buf_tag_d   = mem_addr_q[15:2];
                    buf_valid_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                        state_d = StResp;
                    end else begin
                        mem_wdata_d = merge_bytes(mem_rdata_i, wdata_q, be_q);
                        state_d     = StWrIssue;
                    end
                end
            end
            StWrIssue: begin
                if (mem_req_ready_i) begin
                    mem_write_en_o = 1'b1;
                    state_d        = StWrWlo;
                end
            end
            StWrWlo: begin
                if (!mem_req_ready_i) state_d = StWrWhi;
            end
            StWrWhi: begin
                if (mem_req_ready_i) begin
                    // Keep the buffer coherent with the word just written.
                    if (cur_match) buf_data_d = mem_wdata_q;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered handshake: busy covers acceptance through RESP; ready follows RESP.
        ready_d = (state_q == StResp);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= 16'h0;
            mem_wdata_q <= 32'h0;
            buf_data_q  <= 32'h0;
            buf_tag_q   <= 14'h0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            buf_data_q  <= buf_data_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = ready_q;
    assign cpu_busy_o  = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
